// File: rtl/uart_tx_frame_serializer.sv
// UART transmit serializer: one clk cycle per bit period.
// Frame: start (0), DATA_WIDTH data bits LSB first, optional parity, stop (1).
// All outputs are registered; the line idles high.
//
// Handshake: data_valid acts as "valid" and (state == IDLE) acts as the implied
// "ready". A transfer happens only at a rising edge where both are true. Requests
// made while busy is high are dropped, not queued, so the sender must hold
// data_valid until it sees busy go high.
module uart_tx_frame_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  tx_out,
  output logic                  busy,
  output logic [2:0]            state_dbg
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]            state;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_nxt;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q;
  logic                  par_bit_q;

  assign cnt_nxt   = cnt + CW'(1);
  assign state_dbg = state;

  // Frame sequencer: outputs are loaded with the value for the state being entered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_out    <= 1'b1;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tx_out <= 1'b1;
          busy   <= 1'b0;
          if (data_valid) begin
            // Latch everything so later input changes cannot disturb the frame.
            data_q    <= p_data;
            par_en_q  <= par_en;
            par_bit_q <= (^p_data) ^ par_typ;
            state     <= START;
            tx_out    <= 1'b0;
            busy      <= 1'b1;
          end
        end
        START: begin
          state  <= DATA;
          cnt    <= '0;
          tx_out <= data_q[0];
          busy   <= 1'b1;
        end
        DATA: begin
          busy <= 1'b1;
          if (cnt == LAST_BIT) begin
            cnt <= '0;
            if (par_en_q) begin
              state  <= PARITY;
              tx_out <= par_bit_q;
            end else begin
              state  <= STOP;
              tx_out <= 1'b1;
            end
          end else begin
            cnt    <= cnt_nxt;
            tx_out <= data_q[cnt_nxt];
          end
        end
        PARITY: begin
          state  <= STOP;
          tx_out <= 1'b1;
          busy   <= 1'b1;
        end
        STOP: begin
          // Always pass through one IDLE cycle before the next start bit.
          state  <= IDLE;
          tx_out <= 1'b1;
          busy   <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          cnt    <= '0;
          tx_out <= 1'b1;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame_serializer.sv
// Bench for uart_tx_frame_serializer: a frame-level model predicts {busy, tx_out}
// for every cycle, and directed scenarios pin captured waveforms to literals.
module tb_uart_tx_frame_serializer;

  localparam int DW = 8;

  logic          clk;
  logic          rst;
  logic [DW-1:0] p_data;
  logic          data_valid;
  logic          par_en;
  logic          par_typ;
  logic          tx_out;
  logic          busy;
  logic [2:0]    state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_frame_serializer #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .tx_out     (tx_out),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: queue of expected {busy, tx_out} for upcoming cycles.
  logic [1:0] exp_q[$];
  logic [1:0] cur_exp = 2'b01;
  logic       model_en = 1'b0;

  task automatic push_frame(input logic [DW-1:0] d, input logic pe, input logic pt);
    int ones;
    ones = 0;
    exp_q.push_back(2'b10);
    for (int i = 0; i < DW; i++) begin
      exp_q.push_back({1'b1, d[i]});
      ones += int'(d[i]);
    end
    if (pe) exp_q.push_back({1'b1, ((ones % 2) == 1) ^ pt});
    exp_q.push_back(2'b11);
  endtask

  // Model update at each edge, then compare after outputs settle.
  always @(posedge clk) begin
    if (!rst) begin
      exp_q.delete();
      cur_exp  = 2'b01;
      model_en = 1'b1;
    end else begin
      if (!cur_exp[1] && data_valid) push_frame(p_data, par_en, par_typ);
      if (exp_q.size() > 0) cur_exp = exp_q.pop_front();
      else cur_exp = 2'b01;
    end
    #1;
    if (model_en) check("model busy,tx", {14'd0, busy, tx_out}, {14'd0, cur_exp});
  end

  // Driver: present a request, drop data_valid after the accept edge, record n cycles.
  task automatic run_frame(input logic [DW-1:0] d, input logic pe, input logic pt,
                           input int n, output logic [15:0] txv, output logic [15:0] bsv);
    txv = '0;
    bsv = '0;
    @(negedge clk);
    p_data = d; par_en = pe; par_typ = pt; data_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      txv[i] = tx_out;
      bsv[i] = busy;
      if (i == 0) begin
        @(negedge clk);
        data_valid = 1'b0;
      end
    end
  endtask

  logic [15:0] tv, bv;

  initial begin
    rst = 1'b0; data_valid = 1'b1; p_data = 8'hA5; par_en = 1'b0; par_typ = 1'b0;

    // Reset held with a pending request: line must stay idle.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("reset tx_out", {15'd0, tx_out}, 16'd1);
      check("reset busy", {15'd0, busy}, 16'd0);
    end
    @(negedge clk);
    rst = 1'b1; data_valid = 1'b0;
    @(posedge clk); #1;
    check("post-reset idle", {14'd0, busy, tx_out}, 16'd1);

    // 0xA5 without parity.
    run_frame(8'hA5, 1'b0, 1'b0, 11, tv, bv);
    check("a5 tx", {6'd0, tv[9:0]}, 16'h034A);
    check("a5 busy", {6'd0, bv[9:0]}, 16'h03FF);
    check("a5 idle after", {14'd0, bv[10], tv[10]}, 16'd1);

    // 0xA5 even parity, then odd parity.
    run_frame(8'hA5, 1'b1, 1'b0, 12, tv, bv);
    check("a5 even tx", {5'd0, tv[10:0]}, {5'd0, 11'b10101001010});
    check("a5 even busy", {4'd0, bv[11:0]}, 16'h07FF);
    run_frame(8'hA5, 1'b1, 1'b1, 12, tv, bv);
    check("a5 odd tx", {5'd0, tv[10:0]}, {5'd0, 11'b11101001010});

    // 0xFF odd parity: only the start bit is low.
    run_frame(8'hFF, 1'b1, 1'b1, 12, tv, bv);
    check("ff odd tx", {5'd0, tv[10:0]}, {5'd0, 11'b11111111110});
    check("ff odd busy", {4'd0, bv[11:0]}, 16'h07FF);

    // 0x3C with ignored mid-frame request, then a held request for 0x55.
    tv = '0; bv = '0;
    @(negedge clk);
    p_data = 8'h3C; par_en = 1'b0; par_typ = 1'b0; data_valid = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      tv[i] = tx_out;
      bv[i] = busy;
      @(negedge clk);
      case (i)
        0:  data_valid = 1'b0;
        3:  begin data_valid = 1'b1; p_data = 8'h81; par_en = 1'b1; par_typ = 1'b1; end
        4:  data_valid = 1'b0;
        6:  par_typ = 1'b0;
        7:  begin data_valid = 1'b1; p_data = 8'h55; par_en = 1'b0; par_typ = 1'b0; end
        11: data_valid = 1'b0;
        default: ;
      endcase
    end
    check("3c tx", {6'd0, tv[9:0]}, {6'd0, 10'b1001111000});
    check("3c busy", {6'd0, bv[9:0]}, 16'h03FF);
    check("gap cycle", {14'd0, bv[10], tv[10]}, 16'd1);
    check("held start", {14'd0, bv[11], tv[11]}, 16'd2);
    check("55 first bits", {13'd0, tv[13:11]}, 16'd2);
    repeat (10) @(posedge clk);

    // Reset during data bit 3, then a clean 0x0F odd-parity frame.
    run_frame(8'hA5, 1'b0, 1'b0, 5, tv, bv);
    check("pre-abort bits", {11'd0, tv[4:0]}, {11'd0, 5'b01010});
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort tx_out", {15'd0, tx_out}, 16'd1);
    check("abort busy", {15'd0, busy}, 16'd0);
    @(negedge clk);
    rst = 1'b1;
    run_frame(8'h0F, 1'b1, 1'b1, 12, tv, bv);
    check("0f odd tx", {5'd0, tv[10:0]}, {5'd0, 11'b11000011110});
    check("0f odd busy", {4'd0, bv[11:0]}, 16'h07FF);

    repeat (3) @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
